// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and controller state type for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_INV = 4'd5;
  localparam logic [3:0] OP_CLR = 4'd6;
  localparam logic [3:0] OP_LSL = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8;
  localparam logic [3:0] OP_ASR = 4'd9;
  localparam logic [3:0] OP_ROL = 4'd10;
  localparam logic [3:0] OP_ROR = 4'd11;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op >= OP_LSL) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter: loads on i_start, moves one bit per cycle, pulses o_done
// with the final value and last bit shifted out on the cycle of the last step.
module alu_shift_unit
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [3:0]         i_op,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHAMT_W-1:0] i_amt,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_carry
);

  logic               r_active;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_data;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   w_next;
  logic               w_out_bit;

  always_comb begin
    w_next    = {r_data[WIDTH-2:0], 1'b0};
    w_out_bit = r_data[WIDTH-1];
    case (r_op)
      OP_LSR: begin
        w_next    = {1'b0, r_data[WIDTH-1:1]};
        w_out_bit = r_data[0];
      end
      OP_ASR: begin
        w_next    = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
        w_out_bit = r_data[0];
      end
      OP_ROL: begin
        w_next    = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        w_out_bit = r_data[WIDTH-1];
      end
      OP_ROR: begin
        w_next    = {r_data[0], r_data[WIDTH-1:1]};
        w_out_bit = r_data[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_op     <= OP_LSL;
      r_data   <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_op     <= i_op;
      r_data   <= i_data;
      r_cnt    <= i_amt;
    end else if (r_active) begin
      r_data <= w_next;
      r_cnt  <= r_cnt - SHAMT_W'(1);
      if (r_cnt == SHAMT_W'(1)) r_active <= 1'b0;
    end
  end

  // The final step is handed out combinationally so the top registers it directly.
  assign o_done   = r_active && (r_cnt == SHAMT_W'(1));
  assign o_result = w_next;
  assign o_carry  = w_out_bit;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; single-cycle arithmetic/logic
// ops and multi-cycle shifts/rotates through alu_shift_unit.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             illegal
);

  state_e             r_state, w_state_next;
  logic               r_out_valid, r_carry, r_ovf, r_zero, r_neg, r_ill;
  logic [WIDTH-1:0]   r_out;

  logic               w_accept, w_shift_start, w_shift_done, w_shift_carry;
  logic [SHAMT_W-1:0] w_amt;
  logic [WIDTH-1:0]   w_shift_res, w_res;
  logic [WIDTH:0]     w_sum, w_diff;
  logic               w_c, w_v, w_ill;

  assign in_ready      = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_amt         = in2[SHAMT_W-1:0];
  assign w_shift_start = w_accept && is_shift_op(op) && (w_amt != '0);

  assign w_sum  = {1'b0, in1} + {1'b0, in2};
  assign w_diff = {1'b0, in1} - {1'b0, in2};

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (op)
      OP_ADD: begin
        {w_c, w_res} = w_sum;
        w_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (w_sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        {w_c, w_res} = w_diff;
        w_v = (in1[WIDTH-1] != in2[WIDTH-1]) && (w_diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND: w_res = in1 & in2;
      OP_OR:  w_res = in1 | in2;
      OP_XOR: w_res = in1 ^ in2;
      OP_INV: w_res = ~in1;
      OP_CLR: w_res = '0;
      // Zero-amount shifts complete here without entering the shift unit.
      OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: w_res = in1;
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_shift_start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_shift_done) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_ill       <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_accept && !w_shift_start) begin
        r_out_valid <= 1'b1;
        r_out       <= w_res;
        r_carry     <= w_c;
        r_ovf       <= w_v;
        r_zero      <= (w_res == '0);
        r_neg       <= w_res[WIDTH-1];
        r_ill       <= w_ill;
      end else if (w_shift_done) begin
        r_out_valid <= 1'b1;
        r_out       <= w_shift_res;
        r_carry     <= w_shift_carry;
        r_ovf       <= 1'b0;
        r_zero      <= (w_shift_res == '0);
        r_neg       <= w_shift_res[WIDTH-1];
        r_ill       <= 1'b0;
      end
    end
  end

  alu_shift_unit #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_shift_start),
    .i_op    (op),
    .i_data  (in1),
    .i_amt   (w_amt),
    .o_done  (w_shift_done),
    .o_result(w_shift_res),
    .o_carry (w_shift_carry)
  );

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign carry     = r_carry;
  assign overflow  = r_ovf;
  assign zero      = r_zero;
  assign negative  = r_neg;
  assign illegal   = r_ill;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4 with hand-computed expectations.
module tb_alu_seq;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] in1, in2, out;
  logic         carry, overflow, zero, negative, illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .in1      (in1),
    .in2      (in2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    op       = o;
    in1      = a;
    in2      = b;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; in1 = '0; in2 = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // ADD F+1
    issue(4'd0, 4'hF, 4'h1);
    tick();
    in_valid = 1'b0;
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_out", 32'(out), 32'h0);
    chk("add_carry", 32'(carry), 32'd1);
    chk("add_zero", 32'(zero), 32'd1);
    chk("add_ovf", 32'(overflow), 32'd0);

    // SUB 3-5 then SUB 8-1 back to back
    issue(4'd1, 4'h3, 4'h5);
    tick();
    chk("sub1_out", 32'(out), 32'hE);
    chk("sub1_carry", 32'(carry), 32'd1);
    chk("sub1_neg", 32'(negative), 32'd1);
    chk("sub1_ovf", 32'(overflow), 32'd0);
    issue(4'd1, 4'h8, 4'h1);
    tick();
    in_valid = 1'b0;
    chk("sub2_out", 32'(out), 32'h7);
    chk("sub2_ovf", 32'(overflow), 32'd1);
    chk("sub2_carry", 32'(carry), 32'd0);
    tick();
    chk("sub2_consumed", 32'(out_valid), 32'd0);

    // LSL 1011 by 2; operands changed after accept must be ignored
    issue(4'd7, 4'b1011, 4'd2);
    tick();
    in_valid = 1'b0; in1 = 4'h0; in2 = 4'h0;
    #1;
    chk("lsl_c1_ready", 32'(in_ready), 32'd0);
    chk("lsl_c1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lsl_c2_ready", 32'(in_ready), 32'd0);
    chk("lsl_c2_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lsl_valid", 32'(out_valid), 32'd1);
    chk("lsl_out", 32'(out), 32'b1100);
    chk("lsl_carry", 32'(carry), 32'd0);
    chk("lsl_ready", 32'(in_ready), 32'd1);

    // ROR 0001 by 1
    issue(4'd11, 4'b0001, 4'd1);
    tick();
    in_valid = 1'b0;
    chk("ror_c1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("ror_out", 32'(out), 32'b1000);
    chk("ror_carry", 32'(carry), 32'd1);
    chk("ror_neg", 32'(negative), 32'd1);

    // ASR 1000 by 3
    issue(4'd9, 4'b1000, 4'd3);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("asr_c3_valid", 32'(out_valid), 32'd0);
    tick();
    chk("asr_valid", 32'(out_valid), 32'd1);
    chk("asr_out", 32'(out), 32'hF);
    chk("asr_carry", 32'(carry), 32'd0);

    // LSR by 0 (amount bits of in2 are zero): single-cycle passthrough
    issue(4'd8, 4'h6, 4'h4);
    tick();
    in_valid = 1'b0;
    chk("lsr0_valid", 32'(out_valid), 32'd1);
    chk("lsr0_out", 32'(out), 32'h6);
    chk("lsr0_carry", 32'(carry), 32'd0);

    // Backpressure: AND result held, XOR pending
    issue(4'd2, 4'hC, 4'hA);
    tick();
    out_ready = 1'b0;
    issue(4'd4, 4'hC, 4'hA);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_out", 32'(out), 32'h8);
      chk("bp_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("xor_valid", 32'(out_valid), 32'd1);
    chk("xor_out", 32'(out), 32'h6);

    // Reset on the second cycle of LSL by 3
    issue(4'd7, 4'hF, 4'd3);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_flags", 32'({out, carry, overflow, zero, negative, illegal}), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end

    // Illegal opcode, then ADD 1+1
    issue(4'hF, 4'h5, 4'h3);
    tick();
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_out", 32'(out), 32'h0);
    issue(4'd0, 4'h1, 4'h1);
    tick();
    in_valid = 1'b0;
    chk("post_ill_flag", 32'(illegal), 32'd0);
    chk("post_ill_out", 32'(out), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
